bcd_to_bin_seq: RTL and testbench

BCD_TO_BIN_SEQ -- requirements
Module: bcd_to_bin_seq

---
 rtl/bcd_to_bin_pkg.sv | 20 ++
 rtl/bcd_to_bin_seq_if.sv | 26 ++
 rtl/sub3.sv | 12 +
 rtl/bcd_to_bin_seq.sv | 134 +++++++++++++
 tb/tb_bcd_to_bin_seq.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/bcd_to_bin_pkg.sv
// Shared definitions for the sequential BCD-to-binary converter:
// FSM states, iteration count and reverse double-dabble correction constants.
package bcd_to_bin_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } stateType;

    localparam logic [3:0] ITER_COUNT     = 4'd10;
    localparam logic [3:0] BCD_DIGIT_MAX  = 4'd9;
    localparam logic [3:0] CORR_THRESHOLD = 4'd8;
    localparam logic [3:0] CORR_VALUE     = 4'd3;

    function automatic logic digitInvalid(input logic [3:0] digit);
        return digit > BCD_DIGIT_MAX;
    endfunction

endpackage

// File: rtl/bcd_to_bin_seq_if.sv
// Request/result bundle of the BCD-to-binary converter; the requester drives
// the master side, the converter sits on the slave side.
interface bcd_to_bin_seq_if #(
    parameter int WORD_LENGTH = 8
);
    logic                   enable;
    logic                   start;
    logic [3:0]             H;
    logic [3:0]             T;
    logic [3:0]             U;
    logic                   sign;
    logic [WORD_LENGTH-1:0] bin;
    logic                   busy;
    logic                   done;
    logic                   error;

    modport master (
        output enable, start, H, T, U, sign,
        input  bin, busy, done, error
    );

    modport slave (
        input  enable, start, H, T, U, sign,
        output bin, busy, done, error
    );
endinterface

// File: rtl/sub3.sv
// Reverse double-dabble digit correction: a digit that reached 8 or more after
// a right shift received a borrowed 8 instead of 5, so take 3 back off.
module sub3
    import bcd_to_bin_pkg::*;
(
    input  logic [3:0] digit,
    output logic [3:0] corrected
);

    assign corrected = (digit >= CORR_THRESHOLD) ? (digit - CORR_VALUE) : digit;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential signed BCD (3 digits + sign) to two's-complement converter.
// done rises on the 12th enabled edge counting the edge that samples start.
module bcd_to_bin_seq
    import bcd_to_bin_pkg::*;
#(
    parameter int WORD_LENGTH = 8
)
(
    input  logic           clk,
    input  logic           reset,
    bcd_to_bin_seq_if.slave bus
);

    localparam logic [10:0] MAX_POS     = (11'd1 << (WORD_LENGTH - 1)) - 11'd1;
    localparam logic [10:0] MIN_NEG_MAG = 11'd1 << (WORD_LENGTH - 1);
    localparam logic [WORD_LENGTH-1:0] SAT_POS = WORD_LENGTH'(MAX_POS);
    localparam logic [WORD_LENGTH-1:0] SAT_NEG = WORD_LENGTH'(MIN_NEG_MAG);

    stateType               stateReg;
    logic [11:0]            bcdReg;
    logic [9:0]             magReg;
    logic [3:0]             iterReg;
    logic                   signReg;
    logic                   invalidReg;
    logic [WORD_LENGTH-1:0] binReg;
    logic                   errorReg;
    logic                   doneReg;
    logic                   busyReg;

    logic [21:0]            shiftCat;
    logic [11:0]            bcdNext;
    logic [9:0]             magNext;
    logic                   startInvalid;
    logic [10:0]            magWide;
    logic [WORD_LENGTH-1:0] binNext;
    logic                   errorNext;

    // One reverse double-dabble step: shift the whole {bcd, magnitude} pair right.
    assign shiftCat = {bcdReg, magReg} >> 1;
    assign magNext  = shiftCat[9:0];

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_digit
            sub3 u_sub3 (
                .digit     (shiftCat[10 + 4*gi +: 4]),
                .corrected (bcdNext[4*gi +: 4])
            );
        end
    endgenerate

    assign startInvalid = digitInvalid(bus.H) | digitInvalid(bus.T) | digitInvalid(bus.U);
    assign magWide      = {1'b0, magReg};

    // Range check and saturation; a bad digit wins over any range result.
    always_comb begin
        binNext   = '0;
        errorNext = 1'b0;
        if (invalidReg) begin
            binNext   = '0;
            errorNext = 1'b1;
        end else if (signReg) begin
            if (magWide > MAX_POS) begin
                binNext   = SAT_POS;
                errorNext = 1'b1;
            end else begin
                binNext = WORD_LENGTH'(magWide);
            end
        end else begin
            if (magWide > MIN_NEG_MAG) begin
                binNext   = SAT_NEG;
                errorNext = 1'b1;
            end else begin
                binNext = WORD_LENGTH'(11'd0 - magWide);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateReg   <= IDLE;
            bcdReg     <= '0;
            magReg     <= '0;
            iterReg    <= '0;
            signReg    <= 1'b0;
            invalidReg <= 1'b0;
            binReg     <= '0;
            errorReg   <= 1'b0;
            doneReg    <= 1'b0;
            busyReg    <= 1'b0;
        end else if (bus.enable) begin
            doneReg <= 1'b0;
            case (stateReg)
                IDLE: begin
                    if (bus.start) begin
                        bcdReg     <= {bus.H, bus.T, bus.U};
                        signReg    <= bus.sign;
                        invalidReg <= startInvalid;
                        magReg     <= '0;
                        iterReg    <= '0;
                        busyReg    <= 1'b1;
                        stateReg   <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcdReg <= bcdNext;
                    magReg <= magNext;
                    if (iterReg == ITER_COUNT - 4'd1) begin
                        iterReg  <= '0;
                        stateReg <= FINISH;
                    end else begin
                        iterReg <= iterReg + 4'd1;
                    end
                end
                FINISH: begin
                    binReg   <= binNext;
                    errorReg <= errorNext;
                    doneReg  <= 1'b1;
                    busyReg  <= 1'b0;
                    stateReg <= IDLE;
                end
                default: begin
                    stateReg <= IDLE;
                    busyReg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.bin   = binReg;
    assign bus.error = errorReg;
    assign bus.done  = doneReg;
    assign bus.busy  = busyReg;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed bench for bcd_to_bin_seq (WORD_LENGTH=8): hand-computed results,
// done timing, busy, ignored restart, enable stall and mid-conversion reset.
module tb_bcd_to_bin_seq;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bcd_to_bin_seq_if #(.WORD_LENGTH(8)) bus ();

    bcd_to_bin_seq #(.WORD_LENGTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Edge 1 is the edge that samples start; done is due on enabled edge 12.
    // stallAt>0 drops enable for edges stallAt+1..stallAt+3.
    // restartAt>0 pulses start (other operands) for edge restartAt+1.
    task automatic runConv(input string tag, input logic s,
                           input logic [3:0] h, input logic [3:0] t, input logic [3:0] u,
                           input logic [7:0] expBin, input logic expErr,
                           input int stallAt, input int restartAt);
        int         expDone;
        int         doneEdge;
        int         doneCount;
        logic [7:0] binAtDone;
        logic       errAtDone;
        logic       busyGood;
        expDone   = (stallAt > 0) ? 15 : 12;
        doneEdge  = -1;
        doneCount = 0;
        binAtDone = '0;
        errAtDone = 1'b0;
        busyGood  = 1'b1;
        @(negedge clk);
        bus.sign   = s;
        bus.H      = h;
        bus.T      = t;
        bus.U      = u;
        bus.enable = 1'b1;
        bus.start  = 1'b1;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done) begin
                doneCount++;
                if (doneEdge < 0) begin
                    doneEdge  = cyc;
                    binAtDone = bus.bin;
                    errAtDone = bus.error;
                    if (bus.busy) busyGood = 1'b0;
                end
            end else if (doneEdge < 0 && !bus.busy) begin
                busyGood = 1'b0;
            end
            bus.start = 1'b0;
            if (restartAt > 0 && cyc == restartAt) begin
                bus.start = 1'b1;
                bus.sign  = 1'b1;
                bus.H     = 4'd0;
                bus.T     = 4'd0;
                bus.U     = 4'd1;
            end
            bus.enable = !(stallAt > 0 && cyc >= stallAt && cyc < stallAt + 3);
        end
        $display("conv %s: sign=%0d digits=%0h%0h%0h bin=0x%02h error=%0d doneEdge=%0d",
                 tag, s, h, t, u, binAtDone, errAtDone, doneEdge);
        checkValue({tag, " doneEdge"}, doneEdge, expDone);
        checkValue({tag, " doneCount"}, doneCount, 1);
        checkValue({tag, " bin"}, {24'd0, binAtDone}, {24'd0, expBin});
        checkValue({tag, " error"}, {31'd0, errAtDone}, {31'd0, expErr});
        checkValue({tag, " busy"}, {31'd0, busyGood}, 32'd1);
        checkValue({tag, " binHold"}, {24'd0, bus.bin}, {24'd0, expBin});
    endtask

    initial begin
        int doneSeen;
        reset      = 1'b0;
        bus.enable = 1'b1;
        bus.start  = 1'b0;
        bus.sign   = 1'b1;
        bus.H      = 4'd0;
        bus.T      = 4'd0;
        bus.U      = 4'd0;
        #12;
        checkValue("reset bin",   {24'd0, bus.bin},   32'd0);
        checkValue("reset error", {31'd0, bus.error}, 32'd0);
        checkValue("reset done",  {31'd0, bus.done},  32'd0);
        checkValue("reset busy",  {31'd0, bus.busy},  32'd0);
        @(negedge clk);
        reset = 1'b1;

        runConv("pos127",  1'b1, 4'd1, 4'd2, 4'd7, 8'h7F, 1'b0, 0, 0);
        runConv("neg128",  1'b0, 4'd1, 4'd2, 4'd8, 8'h80, 1'b0, 0, 0);
        runConv("neg5",    1'b0, 4'd0, 4'd0, 4'd5, 8'hFB, 1'b0, 0, 0);
        runConv("negZero", 1'b0, 4'd0, 4'd0, 4'd0, 8'h00, 1'b0, 0, 0);
        runConv("pos200",  1'b1, 4'd2, 4'd0, 4'd0, 8'h7F, 1'b1, 0, 0);
        runConv("neg999",  1'b0, 4'd9, 4'd9, 4'd9, 8'h80, 1'b1, 0, 0);
        runConv("badDig",  1'b1, 4'd0, 4'hA, 4'd3, 8'h00, 1'b1, 0, 0);
        runConv("restart", 1'b1, 4'd0, 4'd4, 4'd2, 8'h2A, 1'b0, 0, 5);
        runConv("stall",   1'b0, 4'd0, 4'd3, 4'd3, 8'hDF, 1'b0, 4, 0);
        runConv("pre",     1'b1, 4'd1, 4'd2, 4'd7, 8'h7F, 1'b0, 0, 0);

        // Abort a conversion mid-SHIFT with an asynchronous reset.
        @(negedge clk);
        bus.sign  = 1'b1;
        bus.H     = 4'd1;
        bus.T     = 4'd2;
        bus.U     = 4'd7;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        checkValue("abort bin",   {24'd0, bus.bin},   32'd0);
        checkValue("abort error", {31'd0, bus.error}, 32'd0);
        checkValue("abort done",  {31'd0, bus.done},  32'd0);
        checkValue("abort busy",  {31'd0, bus.busy},  32'd0);
        @(negedge clk);
        @(negedge clk);
        reset    = 1'b1;
        doneSeen = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (bus.done) doneSeen++;
        end
        $display("abort: done pulses after release=%0d", doneSeen);
        checkValue("abort noDone", doneSeen, 0);

        runConv("after", 1'b1, 4'd0, 4'd6, 4'd4, 8'h40, 1'b0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
